// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Runs one full-adder slice over a WIDTH-bit operand pair, one bit per clock, LSB first.
// The carry is held in a flop between cycles. The result is presented with a one-cycle
// done pulse and held until the end of the next accepted operation.
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the i_sub port (subtract a - b).
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_start in   request, sampled only while idle
//   i_a     in   operand A, captured on an accepted start
//   i_b     in   operand B, captured on an accepted start
//   i_ci    in   carry-in, captured on an accepted start
//   i_sub   in   (SERIAL_ADD_SUB_EN only) 1 = compute a - b
//   o_busy  out  high while a sum is in progress
//   o_done  out  one-cycle pulse when o_s/o_co/o_ovf are valid
//   o_s     out  sum, held after done
//   o_co    out  final carry-out, held after done
//   o_ovf   out  signed overflow, held after done
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s_sh;   // sum shift register, filled from the MSB end
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic [WIDTH-1:0] w_s_next;

  // Single full-adder slice
  assign w_sum = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  assign w_s_next = {w_sum, r_s_sh[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1
  assign w_b_load = i_sub ? ~i_b : i_b;
  assign w_c_load = i_sub ? 1'b1 : i_ci;
`else
  assign w_b_load = i_b;
  assign w_c_load = i_ci;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_s_sh  <= w_s_next;
          r_carry <= w_co;
          if (r_cnt == CntLast) begin
            // r_carry is the carry into the MSB at this point
            r_s     <= w_s_next;
            r_co    <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_co   = r_co;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random regression at
// WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       busy8, done8, co8, ovf8;
  logic [7:0] s8;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub8;
  logic       sub16;
`endif

  logic        start16;
  logic [15:0] a16, b16;
  logic        ci16;
  logic        busy16, done16, co16, ovf16;
  logic [15:0] s16;

  int n_vec;
  int n_err;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(start8),
    .i_a    (a8),
    .i_b    (b8),
    .i_ci   (ci8),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub  (sub8),
`endif
    .o_busy (busy8),
    .o_done (done8),
    .o_s    (s8),
    .o_co   (co8),
    .o_ovf  (ovf8)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(start16),
    .i_a    (a16),
    .i_b    (b16),
    .i_ci   (ci16),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub  (sub16),
`endif
    .o_busy (busy16),
    .o_done (done16),
    .o_s    (s16),
    .o_co   (co16),
    .o_ovf  (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done after the start-sample edge; counts edges and busy cycles.
  task automatic wait_done8(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = busy8 ? 1 : 0;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy8) nbusy++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic sub);
    logic [7:0] eb;
    logic       ec;
    logic [8:0] sum;
    logic       eovf;
    int         cyc, nbusy;
    eb   = sub ? ~b : b;
    ec   = sub ? 1'b1 : ci;
    sum  = {1'b0, a} + {1'b0, eb} + {8'd0, ec};
    eovf = (a[7] == eb[7]) && (sum[7] != a[7]);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = sub;
`endif
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(cyc, nbusy);
    check("lat8", 64'(cyc), 64'd8);
    check("busy_cnt8", 64'(nbusy), 64'd8);
    check("excl8", {63'd0, busy8 & done8}, 64'd0);
    check("s8", {56'd0, s8}, {56'd0, sum[7:0]});
    check("co8", {63'd0, co8}, {63'd0, sum[8]});
    check("ovf8", {63'd0, ovf8}, {63'd0, eovf});
    @(posedge clk); #1;
    check("hold8", {54'd0, done8, busy8, s8}, {54'd0, 2'b00, sum[7:0]});
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] sum;
    logic        eovf;
    int          cyc;
    sum  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    eovf = (a[15] == b[15]) && (sum[15] != a[15]);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; ci16 = ci;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat16", 64'(cyc), 64'd16);
    check("sum16", {46'd0, ovf16, co16, s16}, {46'd0, eovf, sum});
  endtask

  initial begin
    int cyc, nbusy;
    n_vec = 0;
    n_err = 0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b0; sub16 = 1'b0;
`endif
    rst_n = 1'b0;
    #3;
    check("rst_out8", {52'd0, busy8, done8, co8, ovf8, s8}, 64'd0);
    check("rst_out16", {44'd0, busy16, done16, co16, ovf16, s16}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed adds
    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ignored_lat", 64'(cyc), 64'd4);
    check("ignored_s", {56'd0, s8}, 64'h46);

    // Start held high in the done cycle is accepted
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h04; ci8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_busy", {62'd0, busy8, done8}, 64'd2);
    wait_done8(cyc, nbusy);
    check("b2b_lat", 64'(cyc), 64'd8);
    check("b2b_s", {56'd0, s8}, 64'h07);

    // Reset in the 4th RUN cycle aborts with no done
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out", {52'd0, busy8, done8, co8, ovf8, s8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) cyc++;
    end
    check("abort_quiet", 64'(cyc), 64'd0);
    run8(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run8(8'h05, 8'h07, 1'b0, 1'b1);
    run8(8'h80, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
`endif

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    // Corner operands at WIDTH=16
    run16(16'hFFFF, 16'h0001, 1'b0);
    run16(16'h7FFF, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
